// File: rtl/lane_delay_pipe.sv
// Multi-lane programmable delay line: every lane is retimed by a shared depth of 1..MAX_DEPTH cycles,
// with stall, flush and an automatic clear whenever the effective depth changes.
module lane_delay_pipe #(
   parameter int WIDTH     = 8,
   parameter int LANES     = 4,
   parameter int MAX_DEPTH = 6,
   parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     flush,
   input  logic [DW-1:0]            depth,
   input  logic [LANES-1:0]         valid_in,
   input  logic [LANES*WIDTH-1:0]   data_in,
   output logic [LANES-1:0]         valid_out,
   output logic [LANES*WIDTH-1:0]   data_out,
   output logic                     depth_err
);

   logic [LANES-1:0]       vld_stg  [MAX_DEPTH];
   logic [LANES*WIDTH-1:0] data_stg [MAX_DEPTH];
   logic [DW-1:0]          depth_q;
   logic [DW-1:0]          eff;
   logic                   out_of_range;
   logic [LANES*WIDTH-1:0] din_masked;

   // Invalid entries always carry zero data so stale values never leak to the output.
   always_comb begin
      din_masked = '0;
      for (int i = 0; i < LANES; i++) begin
         if (valid_in[i]) din_masked[i*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_of_range = (depth == '0) || (int'(depth) > MAX_DEPTH);
      if (depth == '0)                   eff = DW'(1);
      else if (int'(depth) > MAX_DEPTH)  eff = DW'(MAX_DEPTH);
      else                               eff = depth;
   end

   // Stage registers: a depth change clears in-flight words exactly like flush.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < MAX_DEPTH; k++) begin
            vld_stg[k]  <= '0;
            data_stg[k] <= '0;
         end
         depth_q   <= DW'(1);
         depth_err <= 1'b0;
      end else begin
         depth_err <= out_of_range;
         if (flush || (eff != depth_q)) begin
            depth_q <= eff;
            for (int k = 0; k < MAX_DEPTH; k++) begin
               vld_stg[k]  <= '0;
               data_stg[k] <= '0;
            end
         end else if (en) begin
            vld_stg[0]  <= valid_in;
            data_stg[0] <= din_masked;
            for (int k = 1; k < MAX_DEPTH; k++) begin
               vld_stg[k]  <= vld_stg[k-1];
               data_stg[k] <= data_stg[k-1];
            end
         end
      end
   end

   // Output tap: pure register mux selected by the latched depth.
   always_comb begin
      valid_out = '0;
      data_out  = '0;
      for (int k = 0; k < MAX_DEPTH; k++) begin
         if (int'(depth_q) == k + 1) begin
            valid_out = vld_stg[k];
            data_out  = data_stg[k];
         end
      end
   end

endmodule

// File: tb/tb_lane_delay_pipe.sv
// Bench for lane_delay_pipe: directed scenarios then random traffic, checked every cycle
// against a queue-based delay-line model.
module tb_lane_delay_pipe;
   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int MAXD  = 6;
   localparam int DW    = 3;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   en;
   logic                   flush;
   logic [DW-1:0]          depth;
   logic [LANES-1:0]       valid_in;
   logic [LANES*WIDTH-1:0] data_in;
   logic [LANES-1:0]       valid_out;
   logic [LANES*WIDTH-1:0] data_out;
   logic                   depth_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [LANES-1:0]       v;
      logic [LANES*WIDTH-1:0] d;
   } ent_t;

   ent_t hist[$];   // newest sample first, cleared on reset/flush/depth change
   int   ml = 1;
   logic merr = 1'b0;

   lane_delay_pipe #(.WIDTH(WIDTH), .LANES(LANES), .MAX_DEPTH(MAXD)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .depth(depth),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(valid_out), .data_out(data_out), .depth_err(depth_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ent_t model_out();
      if (hist.size() >= ml) return hist[ml-1];
      return '0;
   endfunction

   // One clock edge: update the model from the inputs sampled at the edge, then compare.
   task automatic step();
      ent_t e;
      ent_t x;
      int   eff;
      @(posedge clk);
      if (!reset) begin
         hist.delete();
         ml   = 1;
         merr = 1'b0;
      end else begin
         merr = (depth == 0) || (int'(depth) > MAXD);
         eff  = (depth == 0) ? 1 : ((int'(depth) > MAXD) ? MAXD : int'(depth));
         if (flush || eff != ml) begin
            ml = eff;
            hist.delete();
         end else if (en) begin
            e.v = valid_in;
            e.d = '0;
            for (int i = 0; i < LANES; i++)
               if (valid_in[i]) e.d[i*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
            hist.push_front(e);
            if (hist.size() > MAXD) void'(hist.pop_back());
         end
      end
      #1;
      x = model_out();
      check("valid_out", 64'(valid_out), 64'(x.v));
      check("data_out",  64'(data_out),  64'(x.d));
      check("depth_err", 64'(depth_err), 64'(merr));
   endtask

   task automatic drive(input logic v0, input logic [7:0] d0);
      valid_in = {3'b000, v0};
      data_in  = {24'h0, d0};
   endtask

   initial begin
      // T1 reset with busy inputs
      reset = 1'b0; en = 1'b1; flush = 1'b0; depth = 3'd3;
      valid_in = 4'hF; data_in = 32'hA5A5A5A5;
      step();
      step();
      check("t1_valid_zero", 64'(valid_out), 64'h0);
      check("t1_err_zero", 64'(depth_err), 64'h0);

      // T2 latency 3 on lane 0
      reset = 1'b1; valid_in = '0; data_in = '0;
      step();                       // depth change 1 -> 3 clears
      step();
      drive(1'b1, 8'h11); step();   // edge t
      drive(1'b0, 8'h00); step();   // t+1
      check("t2_early", 64'(valid_out), 64'h0);
      step();                       // t+2
      check("t2_valid", 64'(valid_out), 64'h1);
      check("t2_data", 64'(data_out[7:0]), 64'h11);
      step();
      check("t2_late", 64'(valid_out), 64'h0);

      // T3 stall in the middle of a stream
      drive(1'b1, 8'h01); step();
      drive(1'b1, 8'h02); step();
      en = 1'b0; drive(1'b1, 8'hEE); step(); step();
      en = 1'b1; drive(1'b1, 8'h03); step();
      drive(1'b0, 8'h00);
      for (int i = 0; i < 4; i++) step();

      // T4 flush with three words in flight at depth 4
      depth = 3'd4; step();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 8'(8'h40 + i)); step(); end
      flush = 1'b1; drive(1'b0, 8'h00); step();
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t4_no_word", 64'(valid_out), 64'h0);
      end

      // T5 depth change while streaming
      depth = 3'd3;
      for (int i = 0; i < 5; i++) begin drive(1'b1, 8'(8'h50 + i)); step(); end
      depth = 3'd1; drive(1'b1, 8'h60); step();
      drive(1'b1, 8'h61); step();
      check("t5_next", 64'(data_out[7:0]), 64'h61);
      drive(1'b0, 8'h00); step(); step();

      // T6 range clamp and error flag
      depth = 3'd0; step();
      check("t6_err_lo", 64'(depth_err), 64'h1);
      depth = 3'd7; drive(1'b1, 8'h77); step();
      check("t6_err_hi", 64'(depth_err), 64'h1);
      drive(1'b0, 8'h00);
      for (int i = 0; i < 7; i++) step();
      depth = 3'd2; step();
      check("t6_err_clr", 64'(depth_err), 64'h0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 99) != 0);
         en       = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 24) == 0) depth = DW'($urandom_range(0, 7));
         valid_in = LANES'($urandom);
         data_in  = $urandom;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
